// File: rtl/verificador_contagem_if.sv
// Bundle of the monitored count stream (into the checker) and the checker's status outputs.
// Direction suffixes are given from the checker's point of view.
interface verificador_contagem_if #(
    parameter int LARGURA  = 3,
    parameter int ERR_W    = 8,
    parameter int VOLTAS_W = 8
);
    logic                valido_i;
    logic [LARGURA-1:0]  contagem_i;
    logic                limpar_i;
    logic                travado_o;
    logic                erro_o;
    logic                erro_faixa_o;
    logic [ERR_W-1:0]    conta_erros_o;
    logic [VOLTAS_W-1:0] voltas_o;

    modport master (
        output valido_i, contagem_i, limpar_i,
        input  travado_o, erro_o, erro_faixa_o, conta_erros_o, voltas_o
    );

    modport slave (
        input  valido_i, contagem_i, limpar_i,
        output travado_o, erro_o, erro_faixa_o, conta_erros_o, voltas_o
    );
endinterface

// File: rtl/verificador_contagem.sv
// Run-time monitor for a mod-MODULO up-counter stream: acquires, locks onto the
// 0..MODULO-1 sequence, then counts wraps and sequence errors.
module verificador_contagem #(
    parameter int LARGURA    = 3,
    parameter int MODULO     = 5,
    parameter int LOCK_COUNT = 2,
    parameter int ERR_W      = 8,
    parameter int VOLTAS_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    verificador_contagem_if.slave  mon
);

    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [LARGURA-1:0] MOD_MAX   = LARGURA'(MODULO - 1);
    localparam logic [LARGURA:0]   MOD_EXT   = (LARGURA + 1)'(MODULO);
    localparam logic [GW-1:0]      LOCK_ALVO = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } estado_t;

    estado_t             estado_q, estado_d;
    logic [LARGURA-1:0]  ref_q, ref_d;
    logic [GW-1:0]       good_q, good_d;
    logic                erro_q, erro_d;
    logic                faixa_q, faixa_d;
    logic [ERR_W-1:0]    conta_q, conta_d;
    logic [VOLTAS_W-1:0] voltas_q, voltas_d;

    logic [LARGURA-1:0]  valor;
    logic [LARGURA-1:0]  esperado;
    logic [GW-1:0]       good_inc;
    logic                fora_faixa;
    logic                inc_erro;
    logic                inc_volta;

    assign valor      = mon.contagem_i;
    assign esperado   = (ref_q == MOD_MAX) ? '0 : ref_q + LARGURA'(1);
    assign good_inc   = good_q + GW'(1);
    // Widened compare so MODULO == 2**LARGURA never flags out-of-range.
    assign fora_faixa = ({1'b0, valor} >= MOD_EXT);

    always_comb begin
        estado_d  = estado_q;
        ref_d     = ref_q;
        good_d    = good_q;
        erro_d    = 1'b0;
        faixa_d   = 1'b0;
        inc_erro  = 1'b0;
        inc_volta = 1'b0;

        if (mon.valido_i) begin
            if (fora_faixa) begin
                faixa_d  = 1'b1;
                estado_d = ST_SYNC;
                good_d   = '0;
                if (estado_q == ST_LOCK) begin
                    erro_d   = 1'b1;
                    inc_erro = 1'b1;
                end
            end else begin
                ref_d = valor;
                case (estado_q)
                    ST_SYNC: begin
                        good_d   = '0;
                        estado_d = ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (valor == esperado) begin
                            good_d = good_inc;
                            if (good_inc == LOCK_ALVO) begin
                                estado_d = ST_LOCK;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    ST_LOCK: begin
                        // A repeated value also lands here: a stalled counter is a mismatch.
                        if (valor == esperado) begin
                            inc_volta = (valor == '0);
                        end else begin
                            erro_d   = 1'b1;
                            inc_erro = 1'b1;
                            good_d   = '0;
                            estado_d = ST_ACQ;
                        end
                    end
                    default: begin
                        good_d   = '0;
                        estado_d = ST_SYNC;
                    end
                endcase
            end
        end
    end

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        conta_d  = conta_q;
        voltas_d = voltas_q;
        if (mon.limpar_i) begin
            conta_d  = '0;
            voltas_d = '0;
        end else begin
            if (inc_erro && (conta_q != '1)) begin
                conta_d = conta_q + ERR_W'(1);
            end
            if (inc_volta) begin
                voltas_d = voltas_q + VOLTAS_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ST_SYNC;
            ref_q    <= '0;
            good_q   <= '0;
            erro_q   <= 1'b0;
            faixa_q  <= 1'b0;
            conta_q  <= '0;
            voltas_q <= '0;
        end else begin
            estado_q <= estado_d;
            ref_q    <= ref_d;
            good_q   <= good_d;
            erro_q   <= erro_d;
            faixa_q  <= faixa_d;
            conta_q  <= conta_d;
            voltas_q <= voltas_d;
        end
    end

    assign mon.travado_o     = (estado_q == ST_LOCK);
    assign mon.erro_o        = erro_q;
    assign mon.erro_faixa_o  = faixa_q;
    assign mon.conta_erros_o = conta_q;
    assign mon.voltas_o      = voltas_q;

endmodule
